hp35_rom_loader: RTL and testbench
==================================

# hp35_rom_loader

Sequencer that owns the write port of the top-level ROM SRAM (32x256) and gates calculator start-up. It receives the microcode image from the Caravel side as a serial bit stream, packs each word, checks parity and writes it to consecutive SRAM addresses. It holds the CTC/ROM reset (`pwo_hold`) until the full image is written, so the ROM read port (`sraddr_mux`/`srdata`, clocked by `phi2`) never fetches a partially loaded image.

## Interface
- `WORDS`, 256: number of SRAM words in one image (1..256).
- `DW`, 30: payload bits per word (three 10-bit ROM words).
- `TIMEOUT`, 1000: maximum idle cycles between bits inside a word before abort (1..65535).

- `osc_in` in 1: the one clock; all state updates on its rising edge.
- `ldr_rst` in 1: reset, synchronous and active-high.
- `ld_start` in 1: single-cycle request to begin a load.
- `ld_skip` in 1: single-cycle request to release `pwo_hold` without loading (forced-data debug).
- `ld_sdin` in 1: serial data bit, LSB first; parity bit last.
- `ld_svalid` in 1: `ld_sdin` is valid this cycle (at most one bit per cycle).
- `sram_csb0` out 1: SRAM port-0 chip select, active-low.
- `sram_web0` out 1: SRAM port-0 write enable, active-low.
- `sram_addr0` out 8: SRAM port-0 address.
- `sram_din0` out 32: SRAM write data, `{2'b0, payload[DW-1:0]}`.
- `pwo_hold` out 1: high holds the calculator in reset; ORed into PWO at top level.
- `ld_busy` out 1: load in progress.
- `ld_done` out 1: image fully written; sticky until next start or reset.
- `ld_err` out 1: load aborted (parity or timeout); sticky.
- `ld_count` out 9: words written in the current or last load.

## Operation
- States: IDLE, SHIFT, WRITE, DONE, ERR.
- IDLE: on `ld_start`, clear the bit counter, `ld_count`, `ld_err` and `ld_done`, then go to SHIFT. On `ld_skip` with no `ld_start`, go to DONE with `ld_count`=0. When both are asserted, `ld_start` wins.
- SHIFT: each `ld_svalid` shifts `ld_sdin` into a DW+1-bit register (LSB first) and resets the idle counter.
  - On the (DW+1)th bit, check even parity over all DW+1 bits (XOR must be 0).
  - Parity pass: copy the payload to the `sram_din0` register and go to WRITE.
  - Parity fail: go to ERR.
- Idle counter: counts cycles without `ld_svalid` only once the first bit of a word has arrived. Reaching TIMEOUT goes to ERR. No timeout applies before the first bit of a word.
- WRITE (exactly one cycle): `sram_csb0`=0, `sram_web0`=0, `sram_addr0`=`ld_count[7:0]`.
  - Next cycle `ld_count` increments.
  - If the new count equals WORDS, go to DONE; otherwise return to SHIFT.
  - A bit presented with `ld_svalid` during WRITE is accepted as bit 0 of the next word; the shift register is separate from the din register.
- DONE: `ld_done`=1, `pwo_hold`=0, `ld_busy`=0. `ld_start` restarts a load (enter SHIFT, `pwo_hold`=1). Bits arriving here are ignored.
- ERR: `ld_err`=1, `pwo_hold`=1, `ld_busy`=0. Only `ld_start` or reset leaves this state; `ld_skip` does not release the hold here.
- `ld_start` during SHIFT or WRITE is ignored. `ld_skip` outside IDLE is ignored.
- Outside WRITE: `sram_csb0`=1 and `sram_web0`=1. `sram_addr0` and `sram_din0` hold their last values.

## Timing
- Reset values: state IDLE, `sram_csb0`=1, `sram_web0`=1, `sram_addr0`=0, `sram_din0`=0, `pwo_hold`=1, `ld_busy`=0, `ld_done`=0, `ld_err`=0, `ld_count`=0.
- Reset takes effect mid-load: the write in flight is dropped if reset coincides with WRITE, and `pwo_hold` returns to 1.
- All outputs are registered.
- `ld_start` in cycle N: `ld_busy`=1 from N+1. The first accepted bit can be in cycle N+1.
- Last bit of a word in cycle N: write strobe (`csb0`/`web0` low) in N+1 with stable addr/din; `ld_count` increments at N+2.
- Final word's write in cycle M: `ld_done`=1 and `pwo_hold`=0 at M+1.
- Parity fail on the bit in cycle N, or timeout expiry in cycle N: `ld_err`=1 at N+1, with no write strobe.
- Minimum load time: WORDS×(DW+1)+1 cycles after start.
- `ld_count` saturates at WORDS; the address wraps only when WORDS=256 (count 256 is never used as an address).

## Test plan
- Reset, then a full load with WORDS=4 and payloads 0x0000_0001, 0x3FFF_FFFF, 0x2AAA_AAAA, 0x1555_5555 (correct parity), bits back-to-back -> 4 write strobes at addresses 0..3 with matching din; `ld_done`=1 and `pwo_hold`=0 one cycle after the 4th strobe; `ld_count`=4.
- Word 2 sent with a flipped parity bit -> no strobe for address 2; `ld_err`=1 and `pwo_hold`=1; `ld_count`=2. Then `ld_start` followed by a good image -> `ld_done`=1.
- Gap of TIMEOUT cycles after bit 5 of word 0 -> `ld_err`=1 at exactly the TIMEOUT-th idle cycle +1. A gap of TIMEOUT-1 cycles completes normally.
- Bit for word 1 presented in the same cycle as word 0's WRITE -> accepted; word 1's din is correct.
- `ld_skip` in IDLE -> `pwo_hold`=0 and `ld_done`=1 next cycle, with no strobes. `ld_skip` in ERR -> no effect. `ldr_rst` mid-load at word 1 -> all outputs return to reset values the next cycle.
- `ld_start` asserted repeatedly while busy -> ignored; the load completes with the correct addresses.

Source files
------------

// File: rtl/hp35_rom_loader_if.sv
// Bus between the Caravel-side image source and the ROM loader.
// Also carries the SRAM port-0 write signals and the start-up status flags.
interface hp35_rom_loader_if;
    logic        ld_start;
    logic        ld_skip;
    logic        ld_sdin;
    logic        ld_svalid;
    logic        sram_csb0;
    logic        sram_web0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic        pwo_hold;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;
    logic [8:0]  ld_count;

    modport master (
        output ld_start, ld_skip, ld_sdin, ld_svalid,
        input  sram_csb0, sram_web0, sram_addr0, sram_din0,
        input  pwo_hold, ld_busy, ld_done, ld_err, ld_count
    );

    modport slave (
        input  ld_start, ld_skip, ld_sdin, ld_svalid,
        output sram_csb0, sram_web0, sram_addr0, sram_din0,
        output pwo_hold, ld_busy, ld_done, ld_err, ld_count
    );
endinterface

// File: rtl/hp35_rom_loader.sv
// Serial microcode loader: packs parity-protected words into the ROM SRAM
// and holds the calculator in reset until a full image has been written.
module hp35_rom_loader #(
    parameter int unsigned WORDS   = 256,
    parameter int unsigned DW      = 30,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             osc_in,
    input  logic             ldr_rst,
    hp35_rom_loader_if.slave ldr
);
    localparam int unsigned BCW = $clog2(DW + 1);
    localparam int unsigned TW  = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]     r_state,  w_state;
    logic [DW-1:0]  r_shift,  w_shift;
    logic [BCW-1:0] r_bitcnt, w_bitcnt;
    logic [TW-1:0]  r_idle,   w_idle;
    logic [8:0]     r_count,  w_count;
    logic [7:0]     r_addr,   w_addr;
    logic [31:0]    r_din,    w_din;
    logic           r_wr_n,   w_wr_n;
    logic           r_busy;
    logic           r_hold;
    logic           r_done;
    logic           r_err;
    logic [DW:0]    w_word;

    // Full word as it stands once the parity bit is the incoming bit.
    assign w_word = {ldr.ld_sdin, r_shift};

    // Next-state and next-register logic.
    always_comb begin
        w_state  = r_state;
        w_shift  = r_shift;
        w_bitcnt = r_bitcnt;
        w_idle   = r_idle;
        w_count  = r_count;
        w_addr   = r_addr;
        w_din    = r_din;
        w_wr_n   = 1'b1;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (ldr.ld_start) begin
                    w_state  = S_SHIFT;
                    w_bitcnt = '0;
                    w_idle   = '0;
                    w_count  = '0;
                end else if (r_state == S_IDLE && ldr.ld_skip) begin
                    w_state = S_DONE;
                    w_count = '0;
                end
            end
            S_SHIFT, S_WRITE: begin
                if (r_state == S_WRITE) begin
                    w_count = r_count + 9'd1;
                    w_state = (w_count == 9'(WORDS)) ? S_DONE : S_SHIFT;
                end
                // A bit arriving during WRITE starts the next word.
                if (ldr.ld_svalid) begin
                    w_idle = '0;
                    if (r_bitcnt == BCW'(DW)) begin
                        w_bitcnt = '0;
                        if (^w_word) begin
                            w_state = S_ERR;
                        end else begin
                            w_state = S_WRITE;
                            w_wr_n  = 1'b0;
                            w_addr  = r_count[7:0];
                            w_din   = 32'(w_word[DW-1:0]);
                        end
                    end else begin
                        w_shift  = w_word[DW:1];
                        w_bitcnt = r_bitcnt + BCW'(1);
                    end
                end else if (r_bitcnt != '0) begin
                    if (r_idle == TW'(TIMEOUT - 1)) begin
                        w_state = S_ERR;
                    end else begin
                        w_idle = r_idle + TW'(1);
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge osc_in) begin
        if (ldr_rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_idle   <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_din    <= '0;
            r_wr_n   <= 1'b1;
            r_busy   <= 1'b0;
            r_hold   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shift  <= w_shift;
            r_bitcnt <= w_bitcnt;
            r_idle   <= w_idle;
            r_count  <= w_count;
            r_addr   <= w_addr;
            r_din    <= w_din;
            r_wr_n   <= w_wr_n;
            r_busy   <= (w_state == S_SHIFT) || (w_state == S_WRITE);
            r_hold   <= (w_state != S_DONE);
            r_done   <= (w_state == S_DONE);
            r_err    <= (w_state == S_ERR);
        end
    end

    assign ldr.sram_csb0  = r_wr_n;
    assign ldr.sram_web0  = r_wr_n;
    assign ldr.sram_addr0 = r_addr;
    assign ldr.sram_din0  = r_din;
    assign ldr.pwo_hold   = r_hold;
    assign ldr.ld_busy    = r_busy;
    assign ldr.ld_done    = r_done;
    assign ldr.ld_err     = r_err;
    assign ldr.ld_count   = r_count;
endmodule

// File: tb/tb_hp35_rom_loader.sv
// Directed bench for hp35_rom_loader: 4-word image, parity/timeout aborts,
// skip, mid-load reset and ignored restarts.
module tb_hp35_rom_loader;
    localparam int unsigned WORDS = 4;
    localparam int unsigned DW    = 30;
    localparam int unsigned TMO   = 20;

    typedef struct {
        logic [29:0] payload;
        logic        par;
        logic [7:0]  addr;
        logic [31:0] din;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    vec_t tbl [4];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_strobe = 0;

    always #5 clk = ~clk;

    hp35_rom_loader_if bus ();

    hp35_rom_loader #(.WORDS(WORDS), .DW(DW), .TIMEOUT(TMO)) dut (
        .osc_in (clk),
        .ldr_rst(rst),
        .ldr    (bus)
    );

    always @(negedge clk)
        if (bus.sram_csb0 == 1'b0 && bus.sram_web0 == 1'b0) n_strobe++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        bus.ld_sdin   = b;
        bus.ld_svalid = 1'b1;
        tick();
        bus.ld_svalid = 1'b0;
    endtask

    task automatic send_word(input int w);
        for (int b = 0; b < 31; b++)
            send_bit((b == 30) ? tbl[w].par : tbl[w].payload[b]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ld_start  = 1'b0;
        bus.ld_skip   = 1'b0;
        bus.ld_svalid = 1'b0;
        bus.ld_sdin   = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_csb"},   32'(bus.sram_csb0),  32'd1);
        chk({tag, "_web"},   32'(bus.sram_web0),  32'd1);
        chk({tag, "_addr"},  32'(bus.sram_addr0), 32'd0);
        chk({tag, "_din"},   bus.sram_din0,       32'd0);
        chk({tag, "_hold"},  32'(bus.pwo_hold),   32'd1);
        chk({tag, "_busy"},  32'(bus.ld_busy),    32'd0);
        chk({tag, "_done"},  32'(bus.ld_done),    32'd0);
        chk({tag, "_err"},   32'(bus.ld_err),     32'd0);
        chk({tag, "_count"}, 32'(bus.ld_count),   32'd0);
    endtask

    // Start a load and stream the table image back-to-back; flip_w corrupts that
    // word's parity, gap inserts idle cycles after bit 5 of word 0, spam holds ld_start.
    task automatic run_load(input int flip_w, input int gap, input bit spam);
        int   s0;
        bit   stop;
        logic bitv;
        s0   = n_strobe;
        stop = 1'b0;
        pulse_start();
        chk("start_busy", 32'(bus.ld_busy),  32'd1);
        chk("start_hold", 32'(bus.pwo_hold), 32'd1);
        for (int w = 0; w < 4 && !stop; w++) begin
            for (int b = 0; b < 31; b++) begin
                bitv = (b == 30) ? (tbl[w].par ^ (w == flip_w)) : tbl[w].payload[b];
                bus.ld_start = spam;
                send_bit(bitv);
                if (b == 0 && w > 0) chk("count_inc", 32'(bus.ld_count), 32'(w));
                if (b == 5 && w == 0 && gap > 0) idle(gap);
            end
            bus.ld_start = 1'b0;
            if (w == flip_w) begin
                chk("perr_csb",    32'(bus.sram_csb0), 32'd1);
                chk("perr_err",    32'(bus.ld_err),    32'd1);
                chk("perr_hold",   32'(bus.pwo_hold),  32'd1);
                chk("perr_busy",   32'(bus.ld_busy),   32'd0);
                chk("perr_count",  32'(bus.ld_count),  32'(flip_w));
                chk("perr_strobes", 32'(n_strobe - s0), 32'(flip_w));
                stop = 1'b1;
            end else begin
                chk("wr_csb",  32'(bus.sram_csb0),  32'd0);
                chk("wr_web",  32'(bus.sram_web0),  32'd0);
                chk("wr_addr", 32'(bus.sram_addr0), 32'(tbl[w].addr));
                chk("wr_din",  bus.sram_din0,       tbl[w].din);
            end
        end
        if (!stop) begin
            tick();
            chk("end_done",    32'(bus.ld_done),   32'd1);
            chk("end_hold",    32'(bus.pwo_hold),  32'd0);
            chk("end_busy",    32'(bus.ld_busy),   32'd0);
            chk("end_csb",     32'(bus.sram_csb0), 32'd1);
            chk("end_count",   32'(bus.ld_count),  32'd4);
            chk("end_strobes", 32'(n_strobe - s0), 32'd4);
        end
    endtask

    initial begin
        int s0;
        tbl[0] = '{payload: 30'h0000_0001, par: 1'b1, addr: 8'd0, din: 32'h0000_0001};
        tbl[1] = '{payload: 30'h3FFF_FFFF, par: 1'b0, addr: 8'd1, din: 32'h3FFF_FFFF};
        tbl[2] = '{payload: 30'h2AAA_AAAA, par: 1'b1, addr: 8'd2, din: 32'h2AAA_AAAA};
        tbl[3] = '{payload: 30'h1555_5555, par: 1'b1, addr: 8'd3, din: 32'h1555_5555};

        do_reset();
        chk_reset("rst");

        run_load(-1, 0, 1'b0);

        do_reset();
        run_load(2, 0, 1'b0);
        run_load(-1, 0, 1'b0);

        // Timeout: gap of TMO idle cycles after bit 5 of word 0.
        do_reset();
        pulse_start();
        for (int b = 0; b < 6; b++) send_bit(tbl[0].payload[b]);
        idle(TMO - 1);
        chk("tmo_early_err", 32'(bus.ld_err), 32'd0);
        tick();
        chk("tmo_err",  32'(bus.ld_err),    32'd1);
        chk("tmo_csb",  32'(bus.sram_csb0), 32'd1);
        chk("tmo_hold", 32'(bus.pwo_hold),  32'd1);
        chk("tmo_busy", 32'(bus.ld_busy),   32'd0);

        // Skip is ignored in ERR.
        bus.ld_skip = 1'b1;
        tick();
        bus.ld_skip = 1'b0;
        tick();
        chk("skip_err_err",  32'(bus.ld_err),   32'd1);
        chk("skip_err_hold", 32'(bus.pwo_hold), 32'd1);
        chk("skip_err_done", 32'(bus.ld_done),  32'd0);

        do_reset();
        run_load(-1, TMO - 1, 1'b0);

        // Skip from IDLE releases the hold without any write.
        do_reset();
        s0 = n_strobe;
        bus.ld_skip = 1'b1;
        tick();
        bus.ld_skip = 1'b0;
        chk("skip_hold",    32'(bus.pwo_hold),  32'd0);
        chk("skip_done",    32'(bus.ld_done),   32'd1);
        chk("skip_busy",    32'(bus.ld_busy),   32'd0);
        chk("skip_count",   32'(bus.ld_count),  32'd0);
        tick();
        chk("skip_strobes", 32'(n_strobe - s0), 32'd0);

        // Reset coinciding with word 1's write strobe.
        do_reset();
        pulse_start();
        send_word(0);
        send_word(1);
        chk("mid_csb",  32'(bus.sram_csb0),  32'd0);
        chk("mid_addr", 32'(bus.sram_addr0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("midrst");

        do_reset();
        run_load(-1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
